// File: rtl/floatingp_point_mult.sv
// floatingp_point_mult
//   Single-cycle-latency multiplier for a small sign/exponent/mantissa format.
//   Operand value = (-1)^s * (M/128) * 2^E, with E a 7-bit two's-complement
//   exponent and M an 8-bit unsigned mantissa that does not have to be
//   normalized. The product is renormalized, then saturated on overflow or
//   flushed to a signed zero on underflow.
//
// Configuration macro:
//   FPMULT_ROUND_EN  - when defined, the discarded product bits are rounded
//                      half-up; otherwise they are truncated and no rounding
//                      hardware exists.
//
// Ports:
//   clk       in   1   clock, rising edge
//   rst       in   1   synchronous active-high reset
//   A, C      in   7   operand-1 / operand-2 exponents (two's complement)
//   B, D      in   8   operand-1 / operand-2 mantissas (0x80 = 1.0)
//   signA     in   1   operand-1 sign (1 = negative)
//   signC     in   1   operand-2 sign (1 = negative)
//   in_valid  in   1   operands valid this cycle
//   out       out 16   {sign, exponent[6:0], mantissa[7:0]}
//   out_valid out  1   out was updated on the previous edge
//   ovf       out  1   current result saturated
//   unf       out  1   current result flushed to zero
module floatingp_point_mult #(
  parameter int EXP_W = 7,
  parameter int MAN_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [EXP_W-1:0]       A,
  input  logic [EXP_W-1:0]       C,
  input  logic [MAN_W-1:0]       B,
  input  logic [MAN_W-1:0]       D,
  input  logic                   signA,
  input  logic                   signC,
  input  logic                   in_valid,
  output logic [EXP_W+MAN_W:0]   out,
  output logic                   out_valid,
  output logic                   ovf,
  output logic                   unf
);

  localparam int PROD_W = 2 * MAN_W;
  localparam int LZ_W   = $clog2(PROD_W);
  // Three guard bits cover the exponent sum, the normalization adjustment
  // and a rounding carry without wrapping.
  localparam int XW     = EXP_W + 3;
  localparam int OUT_W  = EXP_W + MAN_W + 1;

  localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EXP_MIN = XW'(-(1 << (EXP_W - 1)));

  logic                  resSign;
  logic [PROD_W-1:0]     prodRaw;
  logic [LZ_W-1:0]       leadZeros;
  logic                  leadFound;
  logic [PROD_W-1:0]     normProd;
  logic [MAN_W-1:0]      manTrunc;
  logic [MAN_W-1:0]      manFinal;
  logic signed [XW-1:0]  expNorm;
  logic signed [XW-1:0]  expFinal;

  logic [OUT_W-1:0]      out_d, out_q;
  logic                  valid_d, valid_q;
  logic                  ovf_d, ovf_q;
  logic                  unf_d, unf_q;

  assign resSign = signA ^ signC;
  assign prodRaw = B * D;

  // Leading-zero count of the raw product; the highest set bit wins.
  always_comb begin
    leadZeros = '0;
    leadFound = 1'b0;
    for (int i = PROD_W - 1; i >= 0; i--) begin
      if (!leadFound && prodRaw[i]) begin
        leadFound = 1'b1;
        leadZeros = LZ_W'(PROD_W - 1 - i);
      end
    end
  end

  // Shifting the leading one up to the MSB makes the top byte the new
  // mantissa. With the leading one at bit k the exponent adjustment is
  // k-14, which equals 1 - leadZeros.
  assign normProd = prodRaw << leadZeros;
  assign manTrunc = MAN_W'(normProd >> MAN_W);
  assign expNorm  = {{(XW-EXP_W){A[EXP_W-1]}}, A}
                  + {{(XW-EXP_W){C[EXP_W-1]}}, C}
                  + XW'(1)
                  - {{(XW-LZ_W){1'b0}}, leadZeros};

`ifdef FPMULT_ROUND_EN
  logic [MAN_W:0] manRounded;

  assign manRounded = {1'b0, manTrunc} + {{MAN_W{1'b0}}, normProd[MAN_W-1]};

  // A carry out of the mantissa means it rolled over from all-ones, so it
  // renormalizes to 1.0 and the exponent steps up before the range check.
  always_comb begin
    if (manRounded[MAN_W]) begin
      manFinal = {1'b1, {(MAN_W-1){1'b0}}};
      expFinal = expNorm + XW'(1);
    end else begin
      manFinal = manRounded[MAN_W-1:0];
      expFinal = expNorm;
    end
  end
`else
  assign manFinal = manTrunc;
  assign expFinal = expNorm;
`endif

  // Result selection. A zero product outranks the range checks so that a
  // zero mantissa never reports overflow or underflow. Without in_valid the
  // result registers hold and only out_valid drops.
  always_comb begin
    out_d   = out_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    valid_d = 1'b0;
    if (in_valid) begin
      valid_d = 1'b1;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      if (prodRaw == '0) begin
        out_d = {resSign, {(OUT_W-1){1'b0}}};
      end else if (expFinal > EXP_MAX) begin
        out_d = {resSign, 1'b0, {(EXP_W-1){1'b1}}, {MAN_W{1'b1}}};
        ovf_d = 1'b1;
      end else if (expFinal < EXP_MIN) begin
        out_d = {resSign, {(OUT_W-1){1'b0}}};
        unf_d = 1'b1;
      end else begin
        out_d = {resSign, expFinal[EXP_W-1:0], manFinal};
      end
    end
  end

  // Output registers; reset wins over a simultaneous valid input, which is
  // simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;

endmodule

// File: tb/tb_floatingp_point_mult.sv
// Self-checking bench for floatingp_point_mult. Directed cases carry their
// expected results as constants; random back-to-back traffic is checked
// against a shift-based reference model. Expectations travel through a
// scoreboard queue from the cycle they are driven to the cycle they appear.
module tb_floatingp_point_mult;

  typedef struct packed {
    logic [15:0] out;
    logic        ovf;
    logic        unf;
  } exp_t;

  typedef struct packed {
    logic [6:0] a;
    logic [6:0] c;
    logic [7:0] b;
    logic [7:0] d;
    logic       sa;
    logic       sc;
    exp_t       e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  A, C;
  logic [7:0]  B, D;
  logic        signA, signC, in_valid;
  logic [15:0] out;
  logic        out_valid, ovf, unf;

  exp_t sbQ[$];
  int   passCount = 0;
  int   checkCount = 0;

  floatingp_point_mult dut (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .C        (C),
    .B        (B),
    .D        (D),
    .signA    (signA),
    .signC    (signC),
    .in_valid (in_valid),
    .out      (out),
    .out_valid(out_valid),
    .ovf      (ovf),
    .unf      (unf)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  // Reference model: scale the integer product until it lands in [128,255],
  // tracking the exponent of the value man * 2^(ex-7).
  function automatic exp_t model(input logic signed [6:0] a, input logic signed [6:0] c,
                                 input logic [7:0] b, input logic [7:0] d,
                                 input logic sa, input logic sc);
    int   man;
    int   ex;
    int   lastBit;
    exp_t r;
    man     = int'(b) * int'(d);
    ex      = int'(a) + int'(c) - 7;
    lastBit = 0;
    r.ovf   = 1'b0;
    r.unf   = 1'b0;
    if (man == 0) begin
      r.out = {sa ^ sc, 15'h0000};
      return r;
    end
    while (man >= 256) begin
      lastBit = man % 2;
      man     = man / 2;
      ex++;
    end
    while (man < 128) begin
      man = man * 2;
      ex--;
    end
`ifdef FPMULT_ROUND_EN
    if (lastBit == 1) begin
      man++;
      if (man == 256) begin
        man = 128;
        ex++;
      end
    end
`endif
    if (ex > 63) begin
      r.out = {sa ^ sc, 7'h3F, 8'hFF};
      r.ovf = 1'b1;
    end else if (ex < -64) begin
      r.out = {sa ^ sc, 15'h0000};
      r.unf = 1'b1;
    end else begin
      r.out = {sa ^ sc, 7'(ex), 8'(man)};
    end
    return r;
  endfunction

  // Drive one valid operation, record its expectation, step past the edge
  task automatic applyStimulus(input vec_t v);
    A        = v.a;
    C        = v.c;
    B        = v.b;
    D        = v.d;
    signA    = v.sa;
    signC    = v.sc;
    in_valid = 1'b1;
    if (!rst) sbQ.push_back(v.e);
    @(posedge clk);
    #1;
  endtask

  // Idle cycle with junk on the operand inputs
  task automatic idleCycle();
    A        = 7'($urandom);
    C        = 7'($urandom);
    B        = 8'($urandom);
    D        = 8'($urandom);
    signA    = 1'($urandom);
    signC    = 1'($urandom);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    A = '0; C = '0; B = '0; D = '0; signA = 1'b0; signC = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkCount++;
    if (out !== 16'h0000 || out_valid !== 1'b0 || ovf !== 1'b0 || unf !== 1'b0)
      $display("[TB] FAIL reset: got out=%h v=%b ovf=%b unf=%b, want out=0000 v=0 ovf=0 unf=0",
               out, out_valid, ovf, unf);
    else passCount++;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    vec_t v[6];
    exp_t e;
    v[0] = '{7'd1,   7'd3,   8'h80, 8'h40, 1'b0, 1'b0, '{16'h0380, 1'b0, 1'b0}};
    v[1] = '{7'd1,   7'h7D,  8'h80, 8'h40, 1'b0, 1'b1, '{16'hFD80, 1'b0, 1'b0}};
    v[2] = '{7'h7F,  7'd3,   8'h80, 8'h40, 1'b1, 1'b0, '{16'h8180, 1'b0, 1'b0}};
    v[3] = '{7'h7F,  7'h7D,  8'h80, 8'h40, 1'b1, 1'b1, '{16'h7B80, 1'b0, 1'b0}};
    v[4] = '{7'd0,   7'd0,   8'h01, 8'h01, 1'b0, 1'b0, '{16'h7280, 1'b0, 1'b0}};
    v[5] = '{7'd5,   7'h7E,  8'hA0, 8'h80, 1'b0, 1'b0, '{16'h03A0, 1'b0, 1'b0}};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(v[i]);
      e = sbQ.pop_front();
      checkCount++;
      if (out_valid !== 1'b1 || out !== e.out || ovf !== e.ovf || unf !== e.unf)
        $display("[TB] FAIL directed[%0d]: got out=%h v=%b ovf=%b unf=%b, want out=%h v=1 ovf=%b unf=%b",
                 i, out, out_valid, ovf, unf, e.out, e.ovf, e.unf);
      else passCount++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_rounding();
    vec_t v[3];
    exp_t e;
`ifdef FPMULT_ROUND_EN
    v[0] = '{7'd0, 7'd0, 8'hC1, 8'hC1, 1'b0, 1'b0, '{16'h0192, 1'b0, 1'b0}};
    v[1] = '{7'd0, 7'd0, 8'hB5, 8'hB5, 1'b0, 1'b0, '{16'h0180, 1'b0, 1'b0}};
`else
    v[0] = '{7'd0, 7'd0, 8'hC1, 8'hC1, 1'b0, 1'b0, '{16'h0191, 1'b0, 1'b0}};
    v[1] = '{7'd0, 7'd0, 8'hB5, 8'hB5, 1'b0, 1'b0, '{16'h00FF, 1'b0, 1'b0}};
`endif
    v[2] = '{7'd0, 7'd0, 8'hC1, 8'h80, 1'b1, 1'b0, '{16'h80C1, 1'b0, 1'b0}};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(v[i]);
      e = sbQ.pop_front();
      checkCount++;
      if (out_valid !== 1'b1 || out !== e.out || ovf !== e.ovf || unf !== e.unf)
        $display("[TB] FAIL rounding[%0d]: got out=%h v=%b ovf=%b unf=%b, want out=%h v=1 ovf=%b unf=%b",
                 i, out, out_valid, ovf, unf, e.out, e.ovf, e.unf);
      else passCount++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_saturation();
    vec_t v[7];
    exp_t e;
    v[0] = '{7'h3F, 7'h3F, 8'h80, 8'h80, 1'b0, 1'b0, '{16'h3FFF, 1'b1, 1'b0}};
    v[1] = '{7'h1F, 7'h20, 8'h80, 8'h80, 1'b0, 1'b0, '{16'h3F80, 1'b0, 1'b0}};
    v[2] = '{7'h20, 7'h1F, 8'hFF, 8'hFF, 1'b1, 1'b0, '{16'hBFFF, 1'b1, 1'b0}};
    v[3] = '{7'h60, 7'h60, 8'h80, 8'h80, 1'b0, 1'b0, '{16'h4080, 1'b0, 1'b0}};
    v[4] = '{7'h60, 7'h60, 8'h80, 8'h40, 1'b1, 1'b0, '{16'h8000, 1'b0, 1'b1}};
    v[5] = '{7'h40, 7'h40, 8'h01, 8'h01, 1'b0, 1'b0, '{16'h0000, 1'b0, 1'b1}};
`ifdef FPMULT_ROUND_EN
    v[6] = '{7'h1F, 7'h20, 8'hB5, 8'hB5, 1'b0, 1'b0, '{16'h3FFF, 1'b1, 1'b0}};
`else
    v[6] = '{7'h1F, 7'h20, 8'hB5, 8'hB5, 1'b0, 1'b0, '{16'h3FFF, 1'b0, 1'b0}};
`endif
    for (int i = 0; i < 7; i++) begin
      applyStimulus(v[i]);
      e = sbQ.pop_front();
      checkCount++;
      if (out_valid !== 1'b1 || out !== e.out || ovf !== e.ovf || unf !== e.unf)
        $display("[TB] FAIL saturation[%0d]: got out=%h v=%b ovf=%b unf=%b, want out=%h v=1 ovf=%b unf=%b",
                 i, out, out_valid, ovf, unf, e.out, e.ovf, e.unf);
      else passCount++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_zero();
    vec_t v[3];
    exp_t e;
    v[0] = '{7'd2,  7'd5,  8'h00, 8'h55, 1'b1, 1'b0, '{16'h8000, 1'b0, 1'b0}};
    v[1] = '{7'h3F, 7'h3F, 8'h80, 8'h00, 1'b0, 1'b0, '{16'h0000, 1'b0, 1'b0}};
    v[2] = '{7'h40, 7'h40, 8'h00, 8'h00, 1'b1, 1'b1, '{16'h0000, 1'b0, 1'b0}};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(v[i]);
      e = sbQ.pop_front();
      checkCount++;
      if (out_valid !== 1'b1 || out !== e.out || ovf !== e.ovf || unf !== e.unf)
        $display("[TB] FAIL zero[%0d]: got out=%h v=%b ovf=%b unf=%b, want out=%h v=1 ovf=%b unf=%b",
                 i, out, out_valid, ovf, unf, e.out, e.ovf, e.unf);
      else passCount++;
    end
    in_valid = 1'b0;
  endtask

  // A saturated result must stay put, flags included, while in_valid is low
  task automatic test_hold();
    vec_t v;
    exp_t e;
    v = '{7'h3F, 7'h3F, 8'h80, 8'h80, 1'b1, 1'b0, '{16'hBFFF, 1'b1, 1'b0}};
    applyStimulus(v);
    e = sbQ.pop_front();
    for (int i = 0; i < 3; i++) begin
      idleCycle();
      checkCount++;
      if (out_valid !== 1'b0 || out !== e.out || ovf !== e.ovf || unf !== e.unf)
        $display("[TB] FAIL hold[%0d]: got out=%h v=%b ovf=%b unf=%b, want out=%h v=0 ovf=%b unf=%b",
                 i, out, out_valid, ovf, unf, e.out, e.ovf, e.unf);
      else passCount++;
    end
  endtask

  // Reset with a simultaneous valid input clears everything and drops the
  // transaction; the first post-reset input appears one cycle later.
  task automatic test_reset_priority();
    vec_t v;
    exp_t e;
    v = '{7'h3F, 7'h3F, 8'h80, 8'h80, 1'b1, 1'b1, '{16'h3FFF, 1'b1, 1'b0}};
    rst = 1'b1;
    applyStimulus(v);
    checkCount++;
    if (out !== 16'h0000 || out_valid !== 1'b0 || ovf !== 1'b0 || unf !== 1'b0 || sbQ.size() != 0)
      $display("[TB] FAIL reset_priority: got out=%h v=%b ovf=%b unf=%b, want out=0000 v=0 ovf=0 unf=0",
               out, out_valid, ovf, unf);
    else passCount++;
    rst = 1'b0;
    idleCycle();
    v = '{7'd1, 7'd3, 8'h80, 8'h40, 1'b0, 1'b0, '{16'h0380, 1'b0, 1'b0}};
    applyStimulus(v);
    e = sbQ.pop_front();
    checkCount++;
    if (out_valid !== 1'b1 || out !== e.out || ovf !== e.ovf || unf !== e.unf)
      $display("[TB] FAIL first_after_reset: got out=%h v=%b ovf=%b unf=%b, want out=%h v=1 ovf=%b unf=%b",
               out, out_valid, ovf, unf, e.out, e.ovf, e.unf);
    else passCount++;
    in_valid = 1'b0;
  endtask

  // Continuous random traffic, one result per cycle, checked against the model
  task automatic test_back_to_back();
    vec_t v;
    exp_t e;
    for (int i = 0; i < 60; i++) begin
      v.a  = 7'($urandom);
      v.c  = 7'($urandom);
      v.b  = 8'($urandom);
      v.d  = (i % 10 == 3) ? 8'h00 : 8'($urandom);
      v.sa = 1'($urandom);
      v.sc = 1'($urandom);
      v.e  = model(v.a, v.c, v.b, v.d, v.sa, v.sc);
      applyStimulus(v);
      checkCount++;
      if (sbQ.size() == 0) begin
        $display("[TB] FAIL back_to_back[%0d]: scoreboard empty, got out=%h v=%b", i, out, out_valid);
      end else begin
        e = sbQ.pop_front();
        if (out_valid !== 1'b1 || out !== e.out || ovf !== e.ovf || unf !== e.unf)
          $display("[TB] FAIL back_to_back[%0d]: A=%h C=%h B=%h D=%h got out=%h v=%b ovf=%b unf=%b, want out=%h v=1 ovf=%b unf=%b",
                   i, v.a, v.c, v.b, v.d, out, out_valid, ovf, unf, e.out, e.ovf, e.unf);
        else passCount++;
      end
    end
    in_valid = 1'b0;
  endtask

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got %0d checks, want completion", checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence
  initial begin
    test_reset();
    test_directed();
    test_rounding();
    test_saturation();
    test_zero();
    test_hold();
    test_reset_priority();
    test_back_to_back();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/floatingp_point_mult.md
FLOATINGP_POINT_MULT -- requirements
Module: floatingp_point_mult

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter EXP_W, default 7, exponent width; it is the only supported value.
REQ-002 The block SHALL have parameter MAN_W, default 8, mantissa width; it is the only supported value.

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have rst, input, 1: reset, synchronous and active-high.
REQ-005 The block SHALL have A, input, 7: operand-1 exponent, two's complement (-64..63).
REQ-006 The block SHALL have C, input, 7: operand-2 exponent, two's complement.
REQ-007 The block SHALL have B, input, 8: operand-1 mantissa, unsigned, bit7 weight 2^0 (0x80 = 1.0).
REQ-008 The block SHALL have D, input, 8: operand-2 mantissa, same encoding as B.
REQ-009 The block SHALL have signA, input, 1: operand-1 sign (1 = negative).
REQ-010 The block SHALL have signC, input, 1: operand-2 sign (1 = negative).
REQ-011 The block SHALL have in_valid, input, 1: operands valid this cycle.
REQ-012 The block SHALL have out, output, 16: result {sign[15], exponent[14:8], mantissa[7:0]}.
REQ-013 The block SHALL have out_valid, output, 1: out updated on the previous edge.
REQ-014 The block SHALL have ovf, output, 1: the current result saturated.
REQ-015 The block SHALL have unf, output, 1: the current result was flushed to zero.

Function
REQ-016 Operand value SHALL be (-1)^s * (M/128) * 2^E; mantissas need not be normalized (0x40 = 0.5).
REQ-017 Result sign SHALL be signA XOR signC.
REQ-018 Raw exponent SHALL be the sign-extended 8-bit sum A+C, with no intermediate truncation.
REQ-019 Mantissa product SHALL be P = B*D, a 16-bit unsigned value with weight 2^-14.
REQ-020 For leading one at bit k of P: mantissa = (P << (15-k))[15:8]; exponent = A+C+(k-14).
REQ-021 If P == 0, out SHALL be {sign, 7'h00, 8'h00}, with ovf=0 and unf=0.
REQ-022 Default rounding SHALL be truncation of the discarded bits.
REQ-023 If final exponent > 63, out SHALL be {sign, 7'h3F, 8'hFF} and ovf SHALL be 1.
REQ-024 If final exponent < -64, out SHALL be {sign, 15'h0} and unf SHALL be 1.
REQ-025 Latency SHALL be 1 cycle: on an edge with in_valid=1, out, ovf and unf SHALL be computed from that cycle's inputs and out_valid SHALL be 1.
REQ-026 On an edge with in_valid=0, out, ovf and unf SHALL hold their values and out_valid SHALL be 0.
REQ-027 Back-to-back in_valid SHALL produce one result per cycle; there is no backpressure.

Reset
REQ-028 When rst=1 at an edge: out=16'h0000, out_valid=0, ovf=0, unf=0.
REQ-029 rst SHALL take precedence over a simultaneous in_valid, and the input transaction SHALL be discarded.
REQ-030 The first valid result after rst deasserts SHALL appear one cycle after the first in_valid.

Configuration
REQ-031 With macro FPMULT_ROUND_EN defined, rounding SHALL be round-half-up on the discarded product bits.
REQ-032 Under FPMULT_ROUND_EN, a rounding carry out of the mantissa SHALL set mantissa=0x80 and add 1 to the exponent, before the overflow check.
REQ-033 Without FPMULT_ROUND_EN, the block SHALL use truncation only, and no rounding logic is present.

Verification
REQ-034 A=1, C=3, B=0x80, D=0x40, signA=0, signC=0, in_valid=1 -> next cycle out=0x0380, out_valid=1.
REQ-035 A=1, C=-3, B=0x80, D=0x40, signA=0, signC=1 -> out=0xFD80.
REQ-036 A=-1, C=3, signA=1, signC=0 (B, D as in REQ-034) -> out=0x8180.
REQ-037 A=-1, C=-3, signA=1, signC=1 (B, D as in REQ-034) -> out=0x7B80.
REQ-038 A=0, C=0, B=0xC1, D=0xC1 -> out=0x0191 without FPMULT_ROUND_EN, out=0x0192 with it.
REQ-039 A=63, C=63, B=0x80, D=0x80 -> out=0x3FFF, ovf=1.
REQ-040 B=0x00 -> zero result per REQ-021.
REQ-041 rst asserted together with in_valid -> out=0x0000, out_valid=0.
